// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter that shares one slave port between two masters and honours LOCK.
// Latency: grant is registered (CYC -> SCYC_I one cycle); the request mux and response routing are combinational.
// Backpressure: a non-granted master sees no termination and stalls until it owns the slave; nothing is buffered.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   M0_*_O / M1_*_O           master requests (CYC, STB, WE, LOCK, ADR[63:0], DAT[63:0], SEL[7:0], TGA/TGC/TGD[15:0])
//   M0_*_I / M1_*_I           master responses (DAT[63:0], TGD[15:0] broadcast; ACK/ERR/RTY to the granted master only)
//   S*_I                      request to the slave, taken from the granted master, all zero when nobody holds the grant
//   S*_O                      slave response (DAT, TGD, ACK, ERR, RTY)
//   GNT[1:0]                  one-hot registered grant: 01 = M0, 10 = M1, 00 = none
// Build option: define WB_ARB_TIMEOUT_EN to add a watchdog that ends a stalled strobe with ERR
// after TIMEOUT_CYCLES stalled cycles.

module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        M0_CYC_O,
    input  logic        M0_STB_O,
    input  logic        M0_WE_O,
    input  logic        M0_LOCK_O,
    input  logic [63:0] M0_ADR_O,
    input  logic [63:0] M0_DAT_O,
    input  logic [7:0]  M0_SEL_O,
    input  logic [15:0] M0_TGA_O,
    input  logic [15:0] M0_TGC_O,
    input  logic [15:0] M0_TGD_O,
    output logic [63:0] M0_DAT_I,
    output logic [15:0] M0_TGD_I,
    output logic        M0_ACK_I,
    output logic        M0_ERR_I,
    output logic        M0_RTY_I,

    input  logic        M1_CYC_O,
    input  logic        M1_STB_O,
    input  logic        M1_WE_O,
    input  logic        M1_LOCK_O,
    input  logic [63:0] M1_ADR_O,
    input  logic [63:0] M1_DAT_O,
    input  logic [7:0]  M1_SEL_O,
    input  logic [15:0] M1_TGA_O,
    input  logic [15:0] M1_TGC_O,
    input  logic [15:0] M1_TGD_O,
    output logic [63:0] M1_DAT_I,
    output logic [15:0] M1_TGD_I,
    output logic        M1_ACK_I,
    output logic        M1_ERR_I,
    output logic        M1_RTY_I,

    output logic        SCYC_I,
    output logic        SSTB_I,
    output logic        SWE_I,
    output logic        SLOCK_I,
    output logic [63:0] SADR_I,
    output logic [63:0] SDAT_I,
    output logic [7:0]  SSEL_I,
    output logic [15:0] STGA_I,
    output logic [15:0] STGC_I,
    output logic [15:0] STGD_I,
    input  logic [63:0] SDAT_O,
    input  logic [15:0] STGD_O,
    input  logic        SACK_O,
    input  logic        SERR_O,
    input  logic        SRTY_O,

    output logic [1:0]  GNT
);

    // A watchdog limit outside the 16-bit counter range can never be reached.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic        lock;
        logic [63:0] adr;
        logic [63:0] dat;
        logic [7:0]  sel;
        logic [15:0] tga;
        logic [15:0] tgc;
        logic [15:0] tgd;
    } wb_req_t;

    // Encoding doubles as the one-hot GNT value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t  state_q, state_d;
    logic    last_q, last_d;      // last-served master: 0 = M0, 1 = M1
    wb_req_t m0_req, m1_req, sel_req;
    logic    stb_raw;
    logic    wd_hit;

    assign m0_req = {M0_CYC_O, M0_STB_O, M0_WE_O, M0_LOCK_O, M0_ADR_O, M0_DAT_O,
                     M0_SEL_O, M0_TGA_O, M0_TGC_O, M0_TGD_O};
    assign m1_req = {M1_CYC_O, M1_STB_O, M1_WE_O, M1_LOCK_O, M1_ADR_O, M1_DAT_O,
                     M1_SEL_O, M1_TGA_O, M1_TGC_O, M1_TGD_O};

    // Next-state: a tie from IDLE goes to whoever was not served last; releasing
    // an owner hands straight over to a waiting master without an IDLE bubble.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC_O && M1_CYC_O) state_d = last_q ? OWN0 : OWN1;
                else if (M0_CYC_O)        state_d = OWN0;
                else if (M1_CYC_O)        state_d = OWN1;
            end
            OWN0: begin
                if (!M0_CYC_O && !M0_LOCK_O) begin
                    last_d  = 1'b0;
                    state_d = M1_CYC_O ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!M1_CYC_O && !M1_LOCK_O) begin
                    last_d  = 1'b1;
                    state_d = M0_CYC_O ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign GNT = state_q;

    // Request mux: everything reads zero while nobody holds the grant.
    always_comb begin
        sel_req = '0;
        case (state_q)
            OWN0:    sel_req = m0_req;
            OWN1:    sel_req = m1_req;
            default: sel_req = '0;
        endcase
    end

    assign stb_raw = sel_req.cyc & sel_req.stb;

`ifdef WB_ARB_TIMEOUT_EN
    // Counts stalled strobe cycles; the limit is hit during the TIMEOUT_CYCLES-th one.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q;
    logic        slv_term;

    assign slv_term = SACK_O | SERR_O | SRTY_O;
    assign wd_hit   = stb_raw & ~slv_term & (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q) || slv_term || wd_hit) begin
            wd_cnt_q <= '0;
        end else if (stb_raw) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    assign SCYC_I  = sel_req.cyc;
    assign SSTB_I  = stb_raw & ~wd_hit;   // strobe withdrawn in the cycle the watchdog fires
    assign SWE_I   = sel_req.we;
    assign SLOCK_I = sel_req.lock;
    assign SADR_I  = sel_req.adr;
    assign SDAT_I  = sel_req.dat;
    assign SSEL_I  = sel_req.sel;
    assign STGA_I  = sel_req.tga;
    assign STGC_I  = sel_req.tgc;
    assign STGD_I  = sel_req.tgd;

    // Terminations reach the granted master only; read data is broadcast.
    assign M0_ACK_I = (state_q == OWN0) & SACK_O;
    assign M0_ERR_I = (state_q == OWN0) & (SERR_O | wd_hit);
    assign M0_RTY_I = (state_q == OWN0) & SRTY_O;
    assign M1_ACK_I = (state_q == OWN1) & SACK_O;
    assign M1_ERR_I = (state_q == OWN1) & (SERR_O | wd_hit);
    assign M1_RTY_I = (state_q == OWN1) & SRTY_O;

    assign M0_DAT_I = SDAT_O;
    assign M1_DAT_I = SDAT_O;
    assign M0_TGD_I = STGD_O;
    assign M1_TGD_I = STGD_O;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic against an ownership model.
// Latency: expected outputs are queued per cycle and popped by a monitor on the falling edge.
// Backpressure: none modelled; slave responses are driven freely by the stimulus.

module tb_wb_rr_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic        lock[2];
    logic [63:0] adr [2];
    logic [63:0] wdat[2];
    logic [7:0]  sel [2];
    logic [15:0] tga [2];
    logic [15:0] tgc [2];
    logic [15:0] tgd [2];
    logic [63:0] sdat;
    logic [15:0] stgd;
    logic        sack, serr, srty;

    logic [63:0] m0_dat_i, m1_dat_i;
    logic [15:0] m0_tgd_i, m1_tgd_i;
    logic        m0_ack_i, m0_err_i, m0_rty_i, m1_ack_i, m1_err_i, m1_rty_i;
    logic        scyc, sstb, swe, slock;
    logic [63:0] sadr, sdat_i;
    logic [7:0]  ssel;
    logic [15:0] stga, stgc, stgd_i;
    logic [1:0]  gnt;

    wb_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .M0_CYC_O(cyc[0]), .M0_STB_O(stb[0]), .M0_WE_O(we[0]), .M0_LOCK_O(lock[0]),
        .M0_ADR_O(adr[0]), .M0_DAT_O(wdat[0]), .M0_SEL_O(sel[0]),
        .M0_TGA_O(tga[0]), .M0_TGC_O(tgc[0]), .M0_TGD_O(tgd[0]),
        .M0_DAT_I(m0_dat_i), .M0_TGD_I(m0_tgd_i),
        .M0_ACK_I(m0_ack_i), .M0_ERR_I(m0_err_i), .M0_RTY_I(m0_rty_i),
        .M1_CYC_O(cyc[1]), .M1_STB_O(stb[1]), .M1_WE_O(we[1]), .M1_LOCK_O(lock[1]),
        .M1_ADR_O(adr[1]), .M1_DAT_O(wdat[1]), .M1_SEL_O(sel[1]),
        .M1_TGA_O(tga[1]), .M1_TGC_O(tgc[1]), .M1_TGD_O(tgd[1]),
        .M1_DAT_I(m1_dat_i), .M1_TGD_I(m1_tgd_i),
        .M1_ACK_I(m1_ack_i), .M1_ERR_I(m1_err_i), .M1_RTY_I(m1_rty_i),
        .SCYC_I(scyc), .SSTB_I(sstb), .SWE_I(swe), .SLOCK_I(slock),
        .SADR_I(sadr), .SDAT_I(sdat_i), .SSEL_I(ssel),
        .STGA_I(stga), .STGC_I(stgc), .STGD_I(stgd_i),
        .SDAT_O(sdat), .STGD_O(stgd), .SACK_O(sack), .SERR_O(serr), .SRTY_O(srty),
        .GNT(gnt)
    );

    typedef struct packed {
        logic [1:0]   gnt;
        logic [187:0] req;
        logic [2:0]   r0;
        logic [2:0]   r1;
        logic [159:0] bc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: who owns the slave (-1 none), who was served last, watchdog count.
    int owner = -1;
    int last  = 1;
    int wd    = 0;
    bit stb_c, hit_c, term_c;
    bit fix_m0 = 1'b0;

    // Grant history seen on the DUT during the fairness phase.
    bit         rec_en = 1'b0;
    logic [1:0] prev_gnt = 2'b00;
    logic [1:0] gq[$];

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Ownership rules applied at a clock edge using the inputs of the cycle just ended.
    task automatic model_edge();
        int prev;
        prev = owner;
        if (rst) begin
            owner = -1;
            last  = 1;
            wd    = 0;
            return;
        end
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) owner = 1 - last;
            else if (cyc[0])      owner = 0;
            else if (cyc[1])      owner = 1;
        end else if (!cyc[owner] && !lock[owner]) begin
            last  = owner;
            owner = cyc[1 - owner] ? 1 - owner : -1;
        end
        if (owner != prev || term_c || hit_c) wd = 0;
        else if (stb_c)                       wd = wd + 1;
    endtask

    task automatic predict();
        exp_t       e;
        logic [2:0] rsp;
        int         o;
        e      = '0;
        o      = owner;
        term_c = sack | serr | srty;
        stb_c  = 1'b0;
        hit_c  = 1'b0;
        e.gnt  = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
        if (o >= 0) begin
            stb_c = cyc[o] && stb[o];
`ifdef WB_ARB_TIMEOUT_EN
            hit_c = stb_c && !term_c && (wd == TO - 1);
`endif
            e.req = {cyc[o], stb_c & !hit_c, we[o], lock[o], adr[o], wdat[o],
                     sel[o], tga[o], tgc[o], tgd[o]};
            rsp   = {sack, serr | hit_c, srty};
            if (o == 0) e.r0 = rsp;
            else        e.r1 = rsp;
        end
        e.bc = {sdat, sdat, stgd, stgd};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle_in(input bit r, input bit c0, input bit s0, input bit l0,
                            input bit c1, input bit s1, input bit l1,
                            input bit a, input bit er, input bit ry);
        tick();
        rst = r;
        cyc[0] = c0; stb[0] = s0; lock[0] = l0;
        cyc[1] = c1; stb[1] = s1; lock[1] = l1;
        sack = a; serr = er; srty = ry;
        for (int i = 0; i < 2; i++) begin
            adr[i]  = {$urandom(), $urandom()};
            wdat[i] = {$urandom(), $urandom()};
            sel[i]  = 8'($urandom());
            tga[i]  = 16'($urandom());
            tgc[i]  = 16'($urandom());
            tgd[i]  = 16'($urandom());
            we[i]   = 1'($urandom_range(0, 1));
        end
        if (fix_m0) begin
            adr[0] = 64'h1000;
            we[0]  = 1'b1;
        end
        sdat = {$urandom(), $urandom()};
        stgd = 16'($urandom());
        predict();
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rec_en && gnt != 2'b00 && gnt != prev_gnt) gq.push_back(gnt);
            prev_gnt = gnt;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 192'(gnt), 192'(e.gnt));
                chk("slave_req", 192'({scyc, sstb, swe, slock, sadr, sdat_i, ssel, stga, stgc, stgd_i}),
                    192'(e.req));
                chk("m0_rsp", 192'({m0_ack_i, m0_err_i, m0_rty_i}), 192'(e.r0));
                chk("m1_rsp", 192'({m1_ack_i, m1_err_i, m1_rty_i}), 192'(e.r1));
                chk("bcast", 192'({m0_dat_i, m1_dat_i, m0_tgd_i, m1_tgd_i}), 192'(e.bc));
            end
        end
    end

    initial begin
        bit         c[2], l[2];
        int         done_c[2];
        bit         dropped[2];

        rst = 1'b1;
        sack = 1'b0; serr = 1'b0; srty = 1'b0;
        sdat = '0; stgd = '0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; lock[i] = 0;
            adr[i] = '0; wdat[i] = '0; sel[i] = '0; tga[i] = '0; tgc[i] = '0; tgd[i] = '0;
        end

        // Reset state.
        repeat (2) cycle_in(1, 0,0,0, 0,0,0, 1,0,0);

        // Single requester with fixed address and write.
        fix_m0 = 1'b1;
        repeat (3) cycle_in(0, 1,1,0, 0,0,0, 1,0,0);
        fix_m0 = 1'b0;
        repeat (2) cycle_in(0, 0,0,0, 0,0,0, 0,0,0);

        // Simultaneous first request after reset, then handover without a bubble.
        cycle_in(1, 0,0,0, 0,0,0, 0,0,0);
        repeat (2) cycle_in(0, 1,1,0, 1,1,0, 1,0,0);
        repeat (2) cycle_in(0, 0,0,0, 1,1,0, 1,0,0);
        repeat (2) cycle_in(0, 0,0,0, 0,0,0, 0,0,0);

        // Fairness: each master runs four single-beat cycles, dropping CYC for a cycle after its ACK.
        cycle_in(1, 0,0,0, 0,0,0, 0,0,0);
        gq.delete();
        rec_en = 1'b1;
        done_c[0] = 0; done_c[1] = 0; dropped[0] = 0; dropped[1] = 0;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 2; i++) c[i] = (done_c[i] < 4) && !dropped[i];
            cycle_in(0, c[0],1,0, c[1],1,0, 1,0,0);
            for (int i = 0; i < 2; i++) begin
                if (owner == i && c[i]) begin
                    done_c[i]++;
                    dropped[i] = 1'b1;
                end else begin
                    dropped[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        #1;
        rec_en = 1'b0;
        chk("fair_len", 192'(gq.size()), 192'(8));
        for (int i = 0; i < 8; i++)
            if (i < gq.size()) chk("fair_order", 192'(gq[i]), (i % 2 == 1) ? 192'(2'b10) : 192'(2'b01));

        // LOCK hold: M1 keeps the grant across a 3-cycle CYC gap while M0 waits.
        cycle_in(1, 0,0,0, 0,0,0, 0,0,0);
        cycle_in(0, 0,0,0, 1,1,1, 1,0,0);
        cycle_in(0, 1,1,0, 1,1,1, 1,0,0);
        repeat (3) cycle_in(0, 1,1,0, 0,0,1, 0,0,0);
        repeat (2) cycle_in(0, 1,1,0, 1,1,1, 1,0,0);
        repeat (3) cycle_in(0, 1,1,0, 0,0,0, 1,0,0);
        repeat (2) cycle_in(0, 0,0,0, 0,0,0, 0,0,0);

        // Reset in the middle of an M1 transfer, then a tie that must go to M0.
        repeat (3) cycle_in(0, 0,0,0, 1,1,0, 0,0,0);
        cycle_in(1, 1,1,0, 1,1,0, 0,0,0);
        repeat (3) cycle_in(0, 1,1,0, 1,1,0, 0,0,0);
        repeat (2) cycle_in(0, 0,0,0, 0,0,0, 0,0,0);

        // Hung slave: M0 strobes and nobody answers.
        cycle_in(1, 0,0,0, 0,0,0, 0,0,0);
        repeat (20) cycle_in(0, 1,1,0, 0,0,0, 0,0,0);
        cycle_in(0, 1,1,0, 0,0,0, 1,0,0);
        repeat (2) cycle_in(0, 0,0,0, 0,0,0, 0,0,0);

        // Random traffic with persistent CYC/LOCK levels.
        c[0] = 0; c[1] = 0; l[0] = 0; l[1] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) c[i] = !c[i];
                if ($urandom_range(0, 9) == 0) l[i] = !l[i];
            end
            cycle_in($urandom_range(0, 199) == 0,
                     c[0], $urandom_range(0, 3) != 0, l[0],
                     c[1], $urandom_range(0, 3) != 0, l[1],
                     $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 15) == 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drain", 192'(exp_q.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone (64-bit data, 64-bit address, 8-bit select, 16-bit tags) round-robin arbiter.
- Sits between two master agents and the single slave port of the master/slave interconnect, so both masters share the slave.
- Grants one master at a time, muxes its request onto the slave and routes slave responses back to the granted master only.
- Honours LOCK to hold the grant across consecutive cycles; optional watchdog terminates hung cycles with ERR.

Parameters:
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (used only when the optional feature is compiled in; 1..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- M0_CYC_O, M1_CYC_O  input  1  master cycle requests.
- M0_STB_O, M1_STB_O  input  1  master strobes.
- M0_WE_O, M1_WE_O  input  1  write enables.
- M0_LOCK_O, M1_LOCK_O  input  1  bus lock requests.
- M0_ADR_O, M1_ADR_O  input  64  addresses.
- M0_DAT_O, M1_DAT_O  input  64  write data.
- M0_SEL_O, M1_SEL_O  input  8  byte selects.
- M0_TGA_O/TGC_O/TGD_O, M1_TGA_O/TGC_O/TGD_O  input  16 each  address, cycle and data tags.
- M0_DAT_I, M1_DAT_I  output  64  read data, both driven from SDAT_O.
- M0_TGD_I, M1_TGD_I  output  16  read tag, both driven from STGD_O.
- M0_ACK_I/ERR_I/RTY_I, M1_ACK_I/ERR_I/RTY_I  output  1 each  terminations.
- SCYC_I, SSTB_I, SWE_I, SLOCK_I  output  1  to slave.
- SADR_I  output  64  to slave.
- SDAT_I  output  64  to slave.
- SSEL_I  output  8  to slave.
- STGA_I, STGC_I, STGD_I  output  16  to slave.
- SDAT_O  input  64  from slave.
- STGD_O  input  16  from slave.
- SACK_O, SERR_O, SRTY_O  input  1  from slave.
- GNT  output  2  one-hot registered grant (01 = M0, 10 = M1, 00 = none); debug/visibility.

Behaviour:
- Clocking and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, GNT = 00, last-served pointer = M1 (so M0 wins the first tie), watchdog count = 0. All slave outputs and all master ACK/ERR/RTY are 0 while GNT = 00.
- State machine: states IDLE, OWN0, OWN1; GNT is the registered state.
- IDLE:
  - Only M0_CYC_O high -> OWN0.
  - Only M1_CYC_O high -> OWN1.
  - Both high -> grant the master that is not last-served.
  - Neither high -> stay in IDLE.
- OWNx: held while Mx_CYC_O = 1 or Mx_LOCK_O = 1.
- Release condition for OWNx: Mx_CYC_O = 0 and Mx_LOCK_O = 0.
  - On release, last-served becomes x.
  - Other master's CYC high -> go directly to OWN(other) on the same edge (no idle bubble).
  - Otherwise -> IDLE.
- Latency: a request sampled high at edge N reaches the slave after edge N, i.e. one cycle from CYC to SCYC_I.
- Request mux (combinational from GNT):
  - SCYC_I = Mx_CYC_O of the granted master.
  - SSTB_I = Mx_CYC_O & Mx_STB_O of the granted master.
  - SWE_I, SLOCK_I, SADR_I, SDAT_I, SSEL_I, STGA_I, STGC_I, STGD_I taken from the granted master.
  - Each of these is 0 when GNT = 00.
- Response routing:
  - Granted master gets SACK_O/SERR_O/SRTY_O, combinational with no added latency.
  - Non-granted master's ACK/ERR/RTY are held at 0.
  - DAT_I/TGD_I are broadcast to both masters unconditionally.
- Fairness: with both masters requesting continuously and no LOCK, grants alternate per bus cycle.
- LOCK: a locked master keeps the grant through CYC-low gaps; the other master is starved until LOCK drops.
- Reset mid-cycle: rst has priority over every transition. GNT = 00 on the next edge, and slave outputs drop in the same cycle as GNT.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- When defined, a 16-bit watchdog counter:
  - Counts cycles with SSTB_I = 1 and SACK_O = SERR_O = SRTY_O = 0.
  - Clears on any termination, on grant change, and on reset.
  - When count reaches TIMEOUT_CYCLES, the arbiter asserts ERR_I to the granted master for exactly one cycle and forces SSTB_I = 0 in that cycle. The counter then clears.
  - The grant is not revoked by a timeout.
- When the macro is not defined: no counter is present, terminations come only from the slave, and TIMEOUT_CYCLES is ignored.

Test Plan:
- Single requester: M0 asserts CYC/STB, ADR = 64'h1000, WE = 1 -> GNT = 01 one cycle later; SADR_I = 64'h1000; slave ACK appears on M0_ACK_I same cycle; M1_ACK_I stays 0.
- Simultaneous first request: M0 and M1 raise CYC on the same edge after reset -> M0 granted first. After M0 drops CYC, GNT goes 01 -> 10 with no IDLE cycle.
- Fairness: both masters issue 4 back-to-back single-beat cycles each -> grant order 0,1,0,1,0,1,0,1.
- LOCK hold: M1 holds LOCK = 1 with two CYC pulses separated by 3 idle cycles while M0 requests -> GNT stays 10 throughout. M0 is granted one cycle after M1 drops LOCK and CYC.
- Reset mid-transfer: rst = 1 while GNT = 10 and SSTB_I = 1 -> next edge GNT = 00, SCYC_I = SSTB_I = 0. After release, an M0/M1 tie grants M0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): M0 strobes, slave never responds -> M0_ERR_I pulses high for 1 cycle at the 8th stalled cycle, with SSTB_I = 0 that cycle. Without the macro, no ERR ever occurs.
